// File: rtl/beeb_host_bus_if.sv
// 6502-socket bus between the accelerator (master) and the BBC Micro
// motherboard model (slave). The slave owns Phi0 and the read-data drive.
interface beeb_host_bus_if;
  logic        Phi0;
  logic [15:0] Addr;
  logic        R_W_n;
  logic [7:0]  Data_in;
  logic [7:0]  Data_out;
  logic        Data_oe;

  modport master (
    input  Phi0, Data_out, Data_oe,
    output Addr, R_W_n, Data_in
  );

  modport slave (
    output Phi0, Data_out, Data_oe,
    input  Addr, R_W_n, Data_in
  );
endinterface

// File: rtl/beeb_host_bus.sv
// Motherboard end of the 6502 socket bus. Generates Phi0 from cpu_clk,
// latches the bus address on the Phi0 rising edge, stretches FC00-FEFF
// accesses to 1 MHz and serves reads/writes against a synchronous memory.
module beeb_host_bus #(
  parameter int CLK_PER_PHASE  = 16,
  parameter int STRETCH_PHASES = 2,
  parameter int DATA_HOLD      = 2
) (
  input  logic              cpu_clk,
  input  logic              Res_n,
  beeb_host_bus_if.slave    bus,
  output logic [15:0]       mem_A,
  output logic              mem_we,
  output logic [7:0]        mem_D_wr,
  input  logic [7:0]        mem_D_rd,
  output logic              io_cycle,
  output logic              cycle_done
);
  localparam int CW     = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
  localparam int SW     = (STRETCH_PHASES > 1) ? $clog2(STRETCH_PHASES) : 1;
  localparam int HW     = $clog2(DATA_HOLD + 1) + 1;
  localparam int RD_LAT = 2;  // clocks from Phi0 rise to read-data capture

  typedef enum logic [1:0] {LOW, HIGH, STRETCH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   ph_cnt, ph_cnt_nx;
  logic [SW-1:0]   st_cnt, st_cnt_nx;
  logic            ph_tc, rise, fall;

  logic            phi0;
  logic [7:0]      data_out;
  logic            data_oe;
  logic            rw_l;
  logic [HW-1:0]   hold_cnt;
  logic [RD_LAT-1:0] vld_pipe;  // vld_pipe[i] high i+1 clocks after the rise

  assign bus.Phi0     = phi0;
  assign bus.Data_out = data_out;
  assign bus.Data_oe  = data_oe;

  assign ph_tc = (ph_cnt == CW'(CLK_PER_PHASE - 1));

  // Phase sequencer: LOW -> HIGH -> (STRETCH for I/O pages) -> LOW, no idle gap.
  always_comb begin
    state_nx  = state;
    ph_cnt_nx = ph_tc ? '0 : ph_cnt + CW'(1);
    st_cnt_nx = st_cnt;
    rise      = 1'b0;
    fall      = 1'b0;
    case (state)
      LOW: begin
        if (ph_tc) begin
          state_nx = HIGH;
          rise     = 1'b1;
        end
      end
      HIGH: begin
        if (ph_tc) begin
          st_cnt_nx = '0;
          if (io_cycle && (STRETCH_PHASES > 0)) begin
            state_nx = STRETCH;
          end else begin
            state_nx = LOW;
            fall     = 1'b1;
          end
        end
      end
      STRETCH: begin
        if (ph_tc) begin
          if (st_cnt == SW'(STRETCH_PHASES - 1)) begin
            state_nx = LOW;
            fall     = 1'b1;
          end else begin
            st_cnt_nx = st_cnt + SW'(1);
          end
        end
      end
      default: state_nx = LOW;
    endcase
  end

  // State, phase counters and the registered Phi0 (high in HIGH and STRETCH).
  always_ff @(posedge cpu_clk) begin
    if (!Res_n) begin
      state  <= LOW;
      ph_cnt <= '0;
      st_cnt <= '0;
      phi0   <= 1'b0;
    end else begin
      state  <= state_nx;
      ph_cnt <= ph_cnt_nx;
      st_cnt <= st_cnt_nx;
      phi0   <= (state_nx != LOW);
    end
  end

  // Bus cycle datapath: latch at the rise, read capture at rise+2, write
  // strobe and end-of-cycle pulse on the clock after the fall.
  always_ff @(posedge cpu_clk) begin
    if (!Res_n) begin
      vld_pipe   <= '0;
      mem_A      <= '0;
      rw_l       <= 1'b1;
      io_cycle   <= 1'b0;
      mem_we     <= 1'b0;
      mem_D_wr   <= '0;
      cycle_done <= 1'b0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[RD_LAT-2:0], rise};
      mem_we     <= 1'b0;
      cycle_done <= 1'b0;

      if (rise) begin
        mem_A    <= bus.Addr;
        rw_l     <= bus.R_W_n;
        // FF page holds the vectors/ROM and runs at full speed.
        io_cycle <= (bus.Addr[15:8] >= 8'hFC) && (bus.Addr[15:8] <= 8'hFE);
      end

      if (fall) begin
        cycle_done <= 1'b1;
        if (!rw_l) begin
          mem_D_wr <= bus.Data_in;
          // 8000-FBFF and FF00-FFFF are ROM; only RAM and I/O take writes.
          mem_we   <= !(mem_A[15] && !io_cycle);
        end
      end

      // Read drive: a new capture wins over a lingering hold from the last cycle.
      if (vld_pipe[RD_LAT-1] && rw_l) begin
        data_out <= mem_D_rd;
        data_oe  <= 1'b1;
        hold_cnt <= '0;
      end else if (fall && data_oe) begin
        if (DATA_HOLD == 0) data_oe <= 1'b0;
        else                hold_cnt <= HW'(DATA_HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) data_oe <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_beeb_host_bus.sv
// Directed bench for beeb_host_bus: reset, RAM read/write, I/O stretch,
// ROM write protect, address latching and mid-cycle reset.
module tb_beeb_host_bus;
  logic        clk = 1'b0;
  logic        Res_n;
  logic [15:0] mem_A;
  logic        mem_we;
  logic [7:0]  mem_D_wr;
  logic [7:0]  mem_D_rd = 8'h00;
  logic        io_cycle;
  logic        cycle_done;

  int checks   = 0;
  int failures = 0;

  // Per-cycle observations, offsets counted in clocks from the Phi0 rise.
  int          hi_len, lo_len, oe_on, oe_off, we_cnt, we_off, done_cnt, done_off;
  logic [15:0] we_a, a_f;
  logic [7:0]  we_d, dout;
  logic        io;

  beeb_host_bus_if bus();

  beeb_host_bus dut (
    .cpu_clk    (clk),
    .Res_n      (Res_n),
    .bus        (bus.slave),
    .mem_A      (mem_A),
    .mem_we     (mem_we),
    .mem_D_wr   (mem_D_wr),
    .mem_D_rd   (mem_D_rd),
    .io_cycle   (io_cycle),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_pat(input logic [15:0] a);
    if (a == 16'h1234)      return 8'h5A;
    else if (a == 16'hFF00) return 8'h77;
    else                    return a[15:8] ^ a[7:0];
  endfunction

  // Synchronous host memory: data valid one clock after the address.
  always @(posedge clk) mem_D_rd <= rd_pat(mem_A);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Run from just after a rise to just after the next rise. Addr/R_W_n are
  // scrambled mid-HIGH; next-cycle inputs are applied once Phi0 has fallen.
  task automatic measure(input logic [15:0] nx_a, input logic nx_rw, input logic [7:0] nx_d);
    logic fell;
    hi_len = -1; lo_len = -1; oe_on = -1; oe_off = -1;
    we_cnt = 0; we_off = -1; done_cnt = 0; done_off = -1;
    we_a = '0; we_d = '0; a_f = '0; dout = '0; fell = 1'b0;
    io = io_cycle;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 2) dout = bus.Data_out;
      if (k == 3) begin
        bus.Addr  = 16'hFD55;
        bus.R_W_n = ~bus.R_W_n;
      end
      if (bus.Data_oe && oe_on < 0) oe_on = k;
      if (!bus.Data_oe && oe_on >= 0 && oe_off < 0) oe_off = k;
      if (mem_we) begin we_cnt++; we_off = k; we_a = mem_A; we_d = mem_D_wr; end
      if (cycle_done) begin done_cnt++; done_off = k; end
      if (!fell && !bus.Phi0) begin
        fell = 1'b1; hi_len = k; a_f = mem_A;
        bus.Addr = nx_a; bus.R_W_n = nx_rw; bus.Data_in = nx_d;
      end else if (fell && bus.Phi0) begin
        lo_len = k - hi_len;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic seen_we;
    Res_n = 1'b0;
    bus.Addr = 16'h1234; bus.R_W_n = 1'b1; bus.Data_in = 8'h00;

    // Reset: all outputs zero.
    repeat (3) tick();
    chk("rst_phi0", {31'd0, bus.Phi0}, 0);
    chk("rst_oe", {31'd0, bus.Data_oe}, 0);
    chk("rst_dout", {24'd0, bus.Data_out}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_mema", {16'd0, mem_A}, 0);
    chk("rst_dwr", {24'd0, mem_D_wr}, 0);
    chk("rst_io", {31'd0, io_cycle}, 0);
    chk("rst_done", {31'd0, cycle_done}, 0);

    // First rise exactly 16 clocks after release.
    Res_n = 1'b1;
    n = 0;
    while (!bus.Phi0 && n < 100) begin tick(); n++; end
    chk("first_rise", n, 16);

    // Read 0x1234 -> 0x5A.
    measure(16'h0400, 1'b0, 8'hA5);
    chk("rd_hi", hi_len, 16);
    chk("rd_period", hi_len + lo_len, 32);
    chk("rd_io", {31'd0, io}, 0);
    chk("rd_dout", {24'd0, dout}, 32'h5A);
    chk("rd_oe_on", oe_on, 2);
    chk("rd_oe_off", oe_off, 18);
    chk("rd_no_we", we_cnt, 0);
    chk("rd_done", done_off, 16);

    // Write 0x0400 <- 0xA5.
    measure(16'hFE40, 1'b0, 8'h03);
    chk("wr_cnt", we_cnt, 1);
    chk("wr_off", we_off, 16);
    chk("wr_addr", {16'd0, we_a}, 32'h0400);
    chk("wr_data", {24'd0, we_d}, 32'hA5);
    chk("wr_done", done_off, 16);
    chk("wr_done_cnt", done_cnt, 1);
    chk("wr_no_oe", oe_on, -1);

    // I/O write 0xFE40 <- 0x03, stretched high phase.
    measure(16'hFF00, 1'b1, 8'h00);
    chk("io_flag", {31'd0, io}, 1);
    chk("io_hi", hi_len, 48);
    chk("io_lo", lo_len, 16);
    chk("io_we_off", we_off, 48);
    chk("io_we_addr", {16'd0, we_a}, 32'hFE40);
    chk("io_we_data", {24'd0, we_d}, 32'h03);

    // Read 0xFF00: page FF is not I/O.
    measure(16'h8000, 1'b0, 8'h5C);
    chk("ff_io", {31'd0, io}, 0);
    chk("ff_hi", hi_len, 16);
    chk("ff_dout", {24'd0, dout}, 32'h77);

    // ROM writes are dropped but still end the cycle.
    measure(16'hFFFC, 1'b0, 8'hC3);
    chk("rom8000_we", we_cnt, 0);
    chk("rom8000_done", done_off, 16);
    chk("rom8000_mema", {16'd0, a_f}, 32'h8000);
    chk("rom8000_hi", hi_len, 16);

    measure(16'h2000, 1'b0, 8'hEE);
    chk("romfffc_we", we_cnt, 0);
    chk("romfffc_done", done_cnt, 1);
    chk("romfffc_mema", {16'd0, a_f}, 32'hFFFC);

    // Reset at R+8 of a write to 0x2000 aborts it.
    seen_we = 1'b0;
    repeat (8) begin tick(); seen_we |= mem_we | cycle_done; end
    Res_n = 1'b0;
    tick();
    chk("abort_phi0", {31'd0, bus.Phi0}, 0);
    chk("abort_we", {31'd0, mem_we | seen_we}, 0);
    chk("abort_done", {31'd0, cycle_done}, 0);
    chk("abort_mema", {16'd0, mem_A}, 0);
    repeat (2) tick();
    Res_n = 1'b1;
    bus.Addr = 16'h0010; bus.R_W_n = 1'b1;
    n = 0;
    while (!bus.Phi0 && n < 100) begin
      tick(); n++;
      seen_we |= mem_we | cycle_done;
    end
    chk("abort_low", n, 16);
    chk("abort_no_we_after", {31'd0, seen_we}, 0);
    chk("abort_mema_next", {16'd0, mem_A}, 32'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
